// File: rtl/comparator_seq_ctrl.sv
// Multi-cycle magnitude comparator: one SLICE-bit compare per cycle, MSB slice first.
// Latency: o_rsp_valid rises k edges after the accept edge (k = o_cycles, 1..NSLICE).
// Backpressure: accepts only in IDLE; the result is held in DONE until i_rsp_ready.
//
// Ports:
//   i_clk, i_reset               clock, asynchronous active-high reset
//   i_req_valid/o_req_ready      request handshake carrying i_a, i_b, i_signed
//   o_rsp_valid/i_rsp_ready      response handshake carrying o_eq, o_gr, o_lt, o_cycles
//   o_busy                       high while a transaction is in CMP or DONE
module comparator_seq_ctrl #(
    parameter int WIDTH      = 32,
    parameter int SLICE      = 4,
    parameter int EARLY_EXIT = 1,
    localparam int NSLICE    = WIDTH / SLICE,
    localparam int CW        = $clog2(NSLICE) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_eq,
    output logic             o_gr,
    output logic             o_lt,
    output logic [CW-1:0]    o_cycles,
    output logic             o_busy
);

    localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_q, b_q;
    logic [IDXW-1:0]  idx;
    logic             decided;
    logic             gr_p, lt_p;

    logic [SLICE-1:0] sa, sb;
    logic             diff, first_diff, idx_zero, cmp_exit, accept;

    assign sa         = a_q[idx*SLICE +: SLICE];
    assign sb         = b_q[idx*SLICE +: SLICE];
    assign diff       = (sa != sb);
    assign first_diff = diff && !decided;
    assign idx_zero   = (idx == '0);
    // With early exit the first differing slice settles the result; otherwise
    // the walk always runs down to slice 0.
    assign cmp_exit   = ((EARLY_EXIT != 0) && first_diff) || idx_zero;
    assign accept     = (state == S_IDLE) && i_req_valid;

    assign o_req_ready = (state == S_IDLE);
    assign o_rsp_valid = (state == S_DONE);
    assign o_busy      = (state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (i_req_valid) state_n = S_CMP;
            S_CMP:   if (cmp_exit)    state_n = S_DONE;
            S_DONE:  if (i_rsp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            decided  <= 1'b0;
            gr_p     <= 1'b0;
            lt_p     <= 1'b0;
            o_eq     <= 1'b0;
            o_gr     <= 1'b0;
            o_lt     <= 1'b0;
            o_cycles <= '0;
        end else if (accept) begin
            // Flipping both sign bits maps two's-complement order onto unsigned
            // order, so the slice compare needs no separate sign handling.
            a_q     <= i_a ^ {i_signed, {(WIDTH-1){1'b0}}};
            b_q     <= i_b ^ {i_signed, {(WIDTH-1){1'b0}}};
            idx     <= IDXW'(NSLICE - 1);
            decided <= 1'b0;
            gr_p    <= 1'b0;
            lt_p    <= 1'b0;
        end else if (state == S_CMP) begin
            if (first_diff) begin
                decided <= 1'b1;
                gr_p    <= (sa > sb);
                lt_p    <= (sa < sb);
            end
            if (cmp_exit) begin
                // Result outputs only change on the exit edge, so they stay
                // one-hot and stable through DONE and after the handshake.
                o_eq     <= !decided && !diff;
                o_gr     <= first_diff ? (sa > sb) : gr_p;
                o_lt     <= first_diff ? (sa < sb) : lt_p;
                o_cycles <= CW'(NSLICE) - CW'(idx);
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
module tb_comparator_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, rsp_ready, sgn;
    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic        sel;

    logic       u0_req_ready, u0_rsp_valid, u0_eq, u0_gr, u0_lt, u0_busy;
    logic [3:0] u0_cycles;
    logic       u1_req_ready, u1_rsp_valid, u1_eq, u1_gr, u1_lt, u1_busy;
    logic [3:0] u1_cycles;

    logic       m_rsp_valid, m_eq, m_gr, m_lt;
    logic [3:0] m_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    comparator_seq_ctrl #(.WIDTH(32), .SLICE(4), .EARLY_EXIT(1)) u0 (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid[0]), .o_req_ready(u0_req_ready),
        .i_a(op_a[0]), .i_b(op_b[0]), .i_signed(sgn[0]),
        .o_rsp_valid(u0_rsp_valid), .i_rsp_ready(rsp_ready[0]),
        .o_eq(u0_eq), .o_gr(u0_gr), .o_lt(u0_lt),
        .o_cycles(u0_cycles), .o_busy(u0_busy)
    );

    comparator_seq_ctrl #(.WIDTH(32), .SLICE(4), .EARLY_EXIT(0)) u1 (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid[1]), .o_req_ready(u1_req_ready),
        .i_a(op_a[1]), .i_b(op_b[1]), .i_signed(sgn[1]),
        .o_rsp_valid(u1_rsp_valid), .i_rsp_ready(rsp_ready[1]),
        .o_eq(u1_eq), .o_gr(u1_gr), .o_lt(u1_lt),
        .o_cycles(u1_cycles), .o_busy(u1_busy)
    );

    assign m_rsp_valid = sel ? u1_rsp_valid : u0_rsp_valid;
    assign m_eq        = sel ? u1_eq        : u0_eq;
    assign m_gr        = sel ? u1_gr        : u0_gr;
    assign m_lt        = sel ? u1_lt        : u0_lt;
    assign m_cycles    = sel ? u1_cycles    : u0_cycles;

    // Index of the first differing nibble from the top, as a cycle count.
    function automatic int exp_cycles(input logic [31:0] a, input logic [31:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (a[i*4 +: 4] != b[i*4 +: 4]) return 8 - i;
        end
        return 8;
    endfunction

    // Issues one request, waits for the response and consumes it.
    // n = edges from the accept edge until o_rsp_valid was seen.
    task automatic run_txn(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic sg, output int n, output logic eq,
                           output logic gr, output logic lt, output logic [3:0] cyc);
        sel = s;
        @(posedge clk); #1;
        op_a[s] = a; op_b[s] = b; sgn[s] = sg; req_valid[s] = 1'b1;
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        n = 0;
        while (!m_rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: no rsp_valid after %0d edges (dut %0d)", n, s);
        end
        eq = m_eq; gr = m_gr; lt = m_lt; cyc = m_cycles;
        rsp_ready[s] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[s] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (u0_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b need 1", u0_req_ready); end
        n_checks++; if (u0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b need 0", u0_rsp_valid); end
        n_checks++; if ({u0_eq, u0_gr, u0_lt} !== 3'b000) begin n_fail++; $display("FAIL reset_result: got %b need 000", {u0_eq, u0_gr, u0_lt}); end
        n_checks++; if (u0_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d need 0", u0_cycles); end
        n_checks++; if (u0_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", u0_busy); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_unsigned_equal;
        int n; logic eq, gr, lt; logic [3:0] cyc;
        run_txn(1'b0, 32'h12345678, 32'h12345678, 1'b0, n, eq, gr, lt, cyc);
        n_checks++; if ({eq, gr, lt} !== 3'b100) begin n_fail++; $display("FAIL uequal_result: got %b need 100", {eq, gr, lt}); end
        n_checks++; if (cyc !== 4'd8) begin n_fail++; $display("FAIL uequal_cycles: got %0d need 8", cyc); end
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL uequal_latency: got %0d need 8", n); end
    endtask

    task automatic test_msb_slice;
        int n; logic eq, gr, lt; logic [3:0] cyc;
        run_txn(1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, n, eq, gr, lt, cyc);
        n_checks++; if ({eq, gr, lt} !== 3'b010) begin n_fail++; $display("FAIL msb_unsigned_result: got %b need 010", {eq, gr, lt}); end
        n_checks++; if (cyc !== 4'd1) begin n_fail++; $display("FAIL msb_unsigned_cycles: got %0d need 1", cyc); end
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL msb_unsigned_latency: got %0d need 1", n); end
        run_txn(1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1, n, eq, gr, lt, cyc);
        n_checks++; if ({eq, gr, lt} !== 3'b001) begin n_fail++; $display("FAIL msb_signed_result: got %b need 001", {eq, gr, lt}); end
        n_checks++; if (cyc !== 4'd1) begin n_fail++; $display("FAIL msb_signed_cycles: got %0d need 1", cyc); end
    endtask

    task automatic test_last_slice_signed;
        int n; logic eq, gr, lt; logic [3:0] cyc;
        run_txn(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, n, eq, gr, lt, cyc);
        n_checks++; if ({eq, gr, lt} !== 3'b001) begin n_fail++; $display("FAIL last_neg_result: got %b need 001", {eq, gr, lt}); end
        n_checks++; if (cyc !== 4'd8) begin n_fail++; $display("FAIL last_neg_cycles: got %0d need 8", cyc); end
        run_txn(1'b0, 32'h00000005, 32'h00000003, 1'b1, n, eq, gr, lt, cyc);
        n_checks++; if ({eq, gr, lt} !== 3'b010) begin n_fail++; $display("FAIL last_pos_result: got %b need 010", {eq, gr, lt}); end
        n_checks++; if (cyc !== 4'd8) begin n_fail++; $display("FAIL last_pos_cycles: got %0d need 8", cyc); end
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL last_pos_latency: got %0d need 8", n); end
    endtask

    task automatic test_backpressure;
        int n; logic eq, gr, lt; logic [3:0] cyc;
        sel = 1'b0;
        @(posedge clk); #1;
        op_a[0] = 32'h00F00000; op_b[0] = 32'h00E00000; sgn[0] = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (!u0_rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d need 3", n); end
        for (int i = 0; i < 5; i++) begin
            // Competing request while the result is pending must be dropped.
            req_valid[0] = 1'b1; op_a[0] = 32'h0; op_b[0] = 32'h1;
            n_checks++; if ({u0_rsp_valid, u0_eq, u0_gr, u0_lt, u0_cycles, u0_req_ready} !== {1'b1, 3'b010, 4'd3, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold cycle %0d: got v=%b r=%b%b%b c=%0d rdy=%b need v=1 r=010 c=3 rdy=0",
                                   i, u0_rsp_valid, u0_eq, u0_gr, u0_lt, u0_cycles, u0_req_ready);
            end
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        n_checks++; if ({u0_rsp_valid, u0_req_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got v=%b rdy=%b need v=0 rdy=1", u0_rsp_valid, u0_req_ready); end
        n_checks++; if ({u0_gr, u0_cycles} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL bp_result_kept: got gr=%b c=%0d need gr=1 c=3", u0_gr, u0_cycles); end
        run_txn(1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, n, eq, gr, lt, cyc);
        n_checks++; if ({eq, gr, lt, cyc} !== {3'b100, 4'd8}) begin n_fail++; $display("FAIL bp_next_req: got r=%b c=%0d need r=100 c=8", {eq, gr, lt}, cyc); end
    endtask

    task automatic test_reset_mid;
        int n; logic eq, gr, lt; logic [3:0] cyc;
        sel = 1'b0;
        @(posedge clk); #1;
        op_a[0] = 32'h0; op_b[0] = 32'h0; sgn[0] = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (u0_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b need 1", u0_busy); end
        rst = 1'b1;
        #1;
        n_checks++; if ({u0_busy, u0_rsp_valid, u0_req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL midrst_immediate: got busy=%b v=%b rdy=%b need 0 0 1", u0_busy, u0_rsp_valid, u0_req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(1'b0, 32'd1, 32'd2, 1'b0, n, eq, gr, lt, cyc);
        n_checks++; if ({eq, gr, lt, cyc} !== {3'b001, 4'd8}) begin n_fail++; $display("FAIL midrst_after: got r=%b c=%0d need r=001 c=8", {eq, gr, lt}, cyc); end
    endtask

    task automatic test_no_early_exit;
        int n; logic eq, gr, lt; logic [3:0] cyc;
        run_txn(1'b1, 32'h80000000, 32'h00000000, 1'b0, n, eq, gr, lt, cyc);
        n_checks++; if ({eq, gr, lt} !== 3'b010) begin n_fail++; $display("FAIL noee_result: got %b need 010", {eq, gr, lt}); end
        n_checks++; if (cyc !== 4'd8) begin n_fail++; $display("FAIL noee_cycles: got %0d need 8", cyc); end
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL noee_latency: got %0d need 8", n); end
    endtask

    task automatic test_random(input logic s, input int count);
        int n; logic eq, gr, lt; logic [3:0] cyc;
        logic [31:0] a, b; logic sg; logic [2:0] exp_r; int exp_c;
        for (int i = 0; i < count; i++) begin
            a  = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'h1 << $urandom_range(0, 31));
                2:       b = {a[31:16], 16'($urandom)};
                default: b = $urandom;
            endcase
            if (sg) exp_r = {a == b, $signed(a) > $signed(b), $signed(a) < $signed(b)};
            else    exp_r = {a == b, a > b, a < b};
            exp_c = s ? 8 : exp_cycles(a, b);
            run_txn(s, a, b, sg, n, eq, gr, lt, cyc);
            n_checks++; if ({eq, gr, lt} !== exp_r) begin
                n_fail++; $display("FAIL rand_result dut%0d a=%h b=%h s=%b: got %b need %b", s, a, b, sg, {eq, gr, lt}, exp_r);
            end
            n_checks++; if (int'(cyc) !== exp_c || n !== exp_c) begin
                n_fail++; $display("FAIL rand_cycles dut%0d a=%h b=%h: got c=%0d lat=%0d need %0d", s, a, b, cyc, n, exp_c);
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        req_valid = '0; rsp_ready = '0; sgn = '0;
        op_a[0] = '0; op_a[1] = '0; op_b[0] = '0; op_b[1] = '0;
        test_reset();
        test_unsigned_equal();
        test_msb_slice();
        test_last_slice_signed();
        test_backpressure();
        test_reset_mid();
        test_no_early_exit();
        test_random(1'b1, 1000);
        test_random(1'b0, 300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
